// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: HD44780-style LCD write-bus receiver with DDRAM cursor tracking and FWFT capture FIFO
//   clk, rstb (async, active-low)
//   lcd_data/lcd_rs/lcd_rw/lcd_en : LCD bus inputs, synchronised internally
//   rx_valid/rx_ready             : FIFO head handshake; rx_data/rx_rs/rx_addr describe the head
//   cursor_addr                   : tracked DDRAM cursor
//   overflow                      : sticky, a transfer was dropped on a full FIFO
module lcd_bus_receiver #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_EN_HIGH = 1
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic [7:0] lcd_data,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_rs,
  output logic [6:0] rx_addr,
  output logic [6:0] cursor_addr,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [SYNC_STAGES-1:0][10:0] sync_q, sync_d;
  logic                         en_s, rw_s, rs_s;
  logic [7:0]                   data_s;
  logic                         en_prev_q, en_prev_d;
  logic [3:0]                   cnt_q, cnt_d;
  logic                         wr_q, wr_d, wr_rs_q, wr_rs_d;
  logic [7:0]                   wr_data_q, wr_data_d;
  logic [6:0]                   cursor_q, cursor_d, cursor_step;
  logic                         inc_q, inc_d;
  logic [AW-1:0]                wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]                  count_q, count_d;
  logic                         overflow_q, overflow_d;
  logic [15:0]                  last_q, last_d, head;
  logic [15:0]                  mem_q [FIFO_DEPTH];
  logic                         full, push, pop;

  // All bus bits travel through one shared synchroniser so they stay aligned with E
  assign {en_s, rw_s, rs_s, data_s} = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], {lcd_en, lcd_rw, lcd_rs, lcd_data}};
    en_prev_d   = en_s;
    cnt_d       = !en_s ? 4'd0 : &cnt_q ? cnt_q : cnt_q + 4'd1;
    // A write completes when E falls after a long enough high phase and rw marks a write
    wr_d        = en_prev_q && !en_s && cnt_q >= 4'(MIN_EN_HIGH) && !rw_s;
    wr_rs_d     = rs_s;
    wr_data_d   = data_s;
    // Two-line DDRAM map: 0x00-0x27 and 0x40-0x67 chain into one ring; elsewhere plain mod-128
    cursor_step = inc_q ? (cursor_q == 7'h27 ? 7'h40 : cursor_q == 7'h67 ? 7'h00 : cursor_q + 7'd1)
                        : (cursor_q == 7'h00 ? 7'h67 : cursor_q == 7'h40 ? 7'h27 : cursor_q - 7'd1);
    cursor_d    = cursor_q;
    inc_d       = inc_q;
    if (wr_q) begin
      if (wr_rs_q) cursor_d = cursor_step;
      else if (wr_data_q[7]) cursor_d = wr_data_q[6:0];
      else if (wr_data_q[7:2] == 6'b000001) inc_d = wr_data_q[1];
      else if (wr_data_q[7:1] == 7'b0000001) cursor_d = 7'h00;
      else if (wr_data_q == 8'h01) begin
        cursor_d = 7'h00;
        inc_d    = 1'b1;
      end
    end
    rx_valid    = count_q != '0;
    pop         = rx_valid && rx_ready;
    full        = count_q == (AW+1)'(FIFO_DEPTH);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    push        = wr_q && (!full || pop);
    overflow_d  = overflow_q || (wr_q && full && !pop);
    wptr_d      = wptr_q + AW'(push);
    rptr_d      = rptr_q + AW'(pop);
    count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
    head        = mem_q[rptr_q];
    // Outputs hold the most recently popped entry once the FIFO runs empty
    last_d      = pop ? head : last_q;
    {rx_rs, rx_data, rx_addr} = rx_valid ? head : last_q;
    cursor_addr = cursor_q;
    overflow    = overflow_q;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync_q     <= '0;
      en_prev_q  <= 1'b0;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      wr_rs_q    <= 1'b0;
      wr_data_q  <= '0;
      cursor_q   <= '0;
      inc_q      <= 1'b1;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      last_q     <= '0;
    end else begin
      sync_q     <= sync_d;
      en_prev_q  <= en_prev_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      wr_rs_q    <= wr_rs_d;
      wr_data_q  <= wr_data_d;
      cursor_q   <= cursor_d;
      inc_q      <= inc_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      last_q     <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {wr_rs_q, wr_data_q, cursor_q};
  end
endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb_lcd_bus_receiver: self-checking bench for lcd_bus_receiver against a behavioural display model
module tb_lcd_bus_receiver;
  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic [7:0] lcd_data = '0;
  logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0, rx_ready = 1'b0;
  logic       rx_valid, rx_rs, overflow;
  logic [7:0] rx_data;
  logic [6:0] rx_addr, cursor_addr;
  logic       rx_valid3, rx_rs3, overflow3;
  logic [7:0] rx_data3;
  logic [6:0] rx_addr3, cursor_addr3;

  typedef struct packed {logic rs; logic [7:0] d; logic [6:0] addr;} ent_t;
  typedef struct packed {logic rs; logic [7:0] d; logic [6:0] cur;} vec_t;

  ent_t       q[$];
  ent_t       mon_e;
  ent_t       last_pop = '0;
  logic [6:0] m_cursor = '0;
  logic       m_inc = 1'b1, m_ovf = 1'b0;
  int         nchk = 0, nfail = 0, npop = 0, base;
  vec_t       tv[24];

  always #5 clk = ~clk;

  lcd_bus_receiver dut (
    .clk(clk), .rstb(rstb), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_rs(rx_rs), .rx_addr(rx_addr),
    .cursor_addr(cursor_addr), .overflow(overflow)
  );

  lcd_bus_receiver #(.MIN_EN_HIGH(3)) dut3 (
    .clk(clk), .rstb(rstb), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .rx_valid(rx_valid3), .rx_ready(1'b0), .rx_data(rx_data3), .rx_rs(rx_rs3), .rx_addr(rx_addr3),
    .cursor_addr(cursor_addr3), .overflow(overflow3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Cursor move on the 80-cell two-line ring; off-map addresses just count mod 128
  function automatic logic [6:0] step(input logic [6:0] a, input logic up);
    int idx;
    if (int'(a) < 'h28 || (int'(a) >= 'h40 && int'(a) < 'h68)) begin
      idx = int'(a) >= 'h40 ? int'(a) - 'h40 + 40 : int'(a);
      idx = (idx + (up ? 1 : 79)) % 80;
      return 7'(idx >= 40 ? idx - 40 + 'h40 : idx);
    end
    return up ? a + 7'd1 : a - 7'd1;
  endfunction

  task automatic model_apply(input logic rs, input logic rw, input logic [7:0] d);
    ent_t e;
    if (rw) return;
    e.rs = rs; e.d = d; e.addr = m_cursor;
    if (q.size() < 8) q.push_back(e);
    else m_ovf = 1'b1;
    if (rs) m_cursor = step(m_cursor, m_inc);
    else if (d == 8'h01) begin m_cursor = 0; m_inc = 1'b1; end
    else if (d == 8'h02 || d == 8'h03) m_cursor = 0;
    else if (d / 4 == 1) m_inc = d[1];
    else if (d >= 8'h80) m_cursor = d[6:0];
  endtask

  task automatic model_reset();
    q.delete();
    m_cursor = 0;
    m_inc = 1'b1;
    m_ovf = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic rs, input logic rw, input logic [7:0] d, input int w);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
    repeat (w) tick();
    lcd_en = 1'b0;
  endtask

  task automatic lcd_write(input logic rs, input logic rw, input logic [7:0] d, input int w);
    pulse(rs, rw, d, w);
    model_apply(rs, rw, d);
    repeat (4) tick();
  endtask

  task automatic do_reset();
    rstb = 1'b0; lcd_en = 1'b0; lcd_rw = 1'b0; rx_ready = 1'b0;
    repeat (2) tick();
    rstb = 1'b1;
    model_reset();
    tick();
  endtask

  // Consumer-side scoreboard: every accepted beat must match the model's oldest entry
  always @(negedge clk) begin
    if (rstb && rx_valid && rx_ready) begin
      if (q.size() == 0) begin
        nchk++; nfail++;
        $display("FAIL beat_unexpected: got data %0h with empty model queue", rx_data);
      end else begin
        mon_e = q.pop_front();
        chk("beat_data", rx_data, mon_e.d);
        chk("beat_rs", rx_rs, mon_e.rs);
        chk("beat_addr", rx_addr, mon_e.addr);
        last_pop = mon_e;
        npop++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic rs, rw;
    logic [7:0] d;
    tv = '{{1'b0,8'hA7,7'h27}, {1'b1,8'h41,7'h40}, {1'b0,8'h04,7'h40}, {1'b1,8'h42,7'h27},
           {1'b0,8'h01,7'h00}, {1'b1,8'h43,7'h01}, {1'b0,8'hE7,7'h67}, {1'b1,8'h44,7'h00},
           {1'b0,8'h04,7'h00}, {1'b1,8'h45,7'h67}, {1'b0,8'hC0,7'h40}, {1'b1,8'h46,7'h27},
           {1'b0,8'h07,7'h27}, {1'b1,8'h47,7'h40}, {1'b0,8'hFF,7'h7F}, {1'b1,8'h48,7'h00},
           {1'b0,8'h05,7'h00}, {1'b1,8'h49,7'h67}, {1'b0,8'h10,7'h67}, {1'b0,8'h03,7'h00},
           {1'b1,8'h4A,7'h67}, {1'b0,8'hAB,7'h2B}, {1'b1,8'h4B,7'h2A}, {1'b0,8'h01,7'h00}};
    do_reset();
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_rs", rx_rs, 0);
    chk("rst_addr", rx_addr, 0);
    chk("rst_cursor", cursor_addr, 0);
    chk("rst_overflow", overflow, 0);

    rx_ready = 1'b1;
    pulse(1'b1, 1'b0, 8'h48, 4);
    model_apply(1'b1, 1'b0, 8'h48);
    repeat (3) tick();
    chk("latency_k2_valid", rx_valid, 0);
    tick();
    chk("latency_k3_valid", rx_valid, 1);
    lcd_write(1'b1, 1'b0, 8'h69, 4);
    repeat (2) tick();
    chk("hi_cursor", cursor_addr, 7'h02);
    chk("hi_beats", npop, 2);
    chk("hi_drained", rx_valid, 0);

    for (int i = 0; i < 24; i++) begin
      lcd_write(tv[i].rs, 1'b0, tv[i].d, 1 + i % 4);
      chk($sformatf("vec%0d_cursor", i), cursor_addr, tv[i].cur);
    end
    repeat (3) tick();

    do_reset();
    for (int i = 0; i < 10; i++) lcd_write(1'b1, 1'b0, 8'h30 + 8'(i), 1 + i % 3);
    chk("ovf_flag", overflow, 1);
    chk("ovf_cursor", cursor_addr, 7'h0A);
    chk("ovf_head", rx_data, 8'h30);
    base = npop;
    rx_ready = 1'b1;
    repeat (12) tick();
    rx_ready = 1'b0;
    chk("ovf_drain_beats", npop - base, 8);
    chk("ovf_drain_valid", rx_valid, 0);
    chk("ovf_hold_data", rx_data, 8'h37);
    chk("ovf_sticky", overflow, 1);

    do_reset();
    for (int i = 0; i < 8; i++) lcd_write(1'b1, 1'b0, 8'h50 + 8'(i), 2);
    chk("full_no_ovf", overflow, 0);
    base = npop;
    pulse(1'b1, 1'b0, 8'h58, 2);
    repeat (3) tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    model_apply(1'b1, 1'b0, 8'h58);
    repeat (3) tick();
    chk("pushpop_no_ovf", overflow, 0);
    chk("pushpop_cursor", cursor_addr, 7'h09);
    rx_ready = 1'b1;
    repeat (12) tick();
    rx_ready = 1'b0;
    chk("pushpop_beats", npop - base, 9);
    chk("pushpop_last", last_pop.d, 8'h58);
    chk("pushpop_hold", rx_data, 8'h58);

    do_reset();
    lcd_write(1'b0, 1'b1, 8'h41, 5);
    chk("rw_no_push", rx_valid, 0);
    chk("rw_no_push3", rx_valid3, 0);
    lcd_write(1'b1, 1'b0, 8'h41, 2);
    chk("short_no_push3", rx_valid3, 0);
    chk("short_cursor3", cursor_addr3, 0);
    chk("short_push1", rx_valid, 1);
    lcd_write(1'b1, 1'b0, 8'h42, 3);
    chk("min_push3", rx_valid3, 1);
    chk("min_data3", rx_data3, 8'h42);
    chk("min_addr3", rx_addr3, 0);
    chk("min_cursor3", cursor_addr3, 1);
    lcd_write(1'b0, 1'b1, 8'h01, 1);
    chk("rw_cursor", cursor_addr, 2);
    lcd_write(1'b1, 1'b0, 8'h43, 4);
    chk("three_queued_cursor", cursor_addr, 3);

    lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h44; lcd_en = 1'b1;
    repeat (2) tick();
    rstb = 1'b0;
    #1;
    chk("midrst_valid", rx_valid, 0);
    chk("midrst_data", rx_data, 0);
    chk("midrst_rs", rx_rs, 0);
    chk("midrst_addr", rx_addr, 0);
    chk("midrst_cursor", cursor_addr, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_valid3", rx_valid3, 0);
    chk("midrst_cursor3", cursor_addr3, 0);
    repeat (2) tick();
    rstb = 1'b1;
    model_reset();
    tick();
    lcd_en = 1'b0;
    model_apply(1'b1, 1'b0, 8'h44);
    repeat (4) tick();
    chk("postrst_no_push3", rx_valid3, 0);
    chk("postrst_cursor3", cursor_addr3, 0);
    chk("postrst_push1", rx_valid, 1);
    chk("postrst_data1", rx_data, 8'h44);
    chk("postrst_cursor1", cursor_addr, 1);

    do_reset();
    for (int i = 0; i < 60; i++) begin
      rs = 1'($urandom_range(0, 1));
      rw = $urandom_range(0, 7) == 0;
      d = 8'($urandom);
      rx_ready = q.size() >= 6 || $urandom_range(0, 3) != 0;
      lcd_write(rs, rw, d, $urandom_range(1, 5));
      chk($sformatf("rand%0d_cursor", i), cursor_addr, m_cursor);
      chk($sformatf("rand%0d_overflow", i), overflow, m_ovf);
    end
    rx_ready = 1'b1;
    repeat (15) tick();
    rx_ready = 1'b0;
    chk("rand_drained", rx_valid, 0);
    chk("rand_model_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/lcd_bus_receiver.md
Name: lcd_bus_receiver

Overview:
- Receiver and monitor for the HD44780-style parallel LCD write bus (lcd_data/lcd_rs/lcd_rw/lcd_en) that our LCD driver produces.
- Synchronises the bus into clk and detects completed write strobes (falling edge of E).
- Decodes each strobe as a character or a command, tracks the DDRAM cursor address, and queues captured transfers in a small FIFO with a valid/ready output.
- Used as an on-chip loopback checker and as a bus-side display model in simulation.

Parameters:
- FIFO_DEPTH, 8, number of queued transfers; power of 2, minimum 2.
- SYNC_STAGES, 2, synchroniser flops on all LCD bus inputs; minimum 2.
- MIN_EN_HIGH, 1, minimum synchronised cycles E must be high for a strobe to count (glitch filter); range 1..15.

Ports:
- clk  in  1  system clock
- rstb  in  1  reset, asynchronous, active-low
- lcd_data  in  8  LCD data bus
- lcd_rs  in  1  1 = data register, 0 = instruction register
- lcd_rw  in  1  1 = read, 0 = write
- lcd_en  in  1  LCD enable strobe
- rx_valid  out  1  FIFO head valid
- rx_ready  in  1  consumer accepts head
- rx_data  out  8  captured byte
- rx_rs  out  1  captured rs (1 = character, 0 = command)
- rx_addr  out  7  cursor address before this transfer was applied
- cursor_addr  out  7  current tracked DDRAM cursor
- overflow  out  1  sticky: a transfer was dropped because the FIFO was full

Behaviour:
- Reset values: rx_valid=0, rx_data=0, rx_rs=0, rx_addr=0, cursor_addr=0, overflow=0. FIFO is empty, entry mode is increment, en-high counter is 0.
- Synchronisation: lcd_en, lcd_rs, lcd_rw and lcd_data each pass through SYNC_STAGES flops, so they stay mutually aligned. The block relies on the writer holding rs/rw/data stable across the E pulse.
- Strobe filter: a saturating 4-bit counter increments while synced E=1 and clears while E=0.
  - A strobe is the cycle where synced E goes 1->0 and the counter is >= MIN_EN_HIGH.
  - Shorter pulses are ignored silently.
- Capture: on a strobe with synced rw=0, push {rs, data, cursor_addr} into the FIFO and update the cursor in the same cycle. A strobe with rw=1 is ignored: no push, no cursor change.
- Latency: the first clk edge that samples lcd_en=0 at the pin is edge k. The push happens at edge k+SYNC_STAGES, and rx_valid=1 after edge k+SYNC_STAGES+1.
- Cursor update (7-bit DDRAM, 2-line map 0x00-0x27, 0x40-0x67):
  - rs=1, increment mode: +1, wrapping 0x27->0x40 and 0x67->0x00.
  - rs=1, decrement mode: -1, wrapping 0x00->0x67 and 0x40->0x27.
  - rs=0, data=0x01 (clear): cursor=0x00 and mode=increment.
  - rs=0, data=0x02 or 0x03 (home): cursor=0x00.
  - rs=0, data[7:2]=000001 (entry mode set): mode = data[1] (1 = increment). Shift bit data[0] is ignored.
  - rs=0, data[7]=1 (set DDRAM address): cursor=data[6:0] taken verbatim, including unmapped addresses. Increment/decrement from an unmapped address is plain +1/-1 modulo 128.
  - All other commands: no cursor change.
- Cursor tracking runs whether or not the FIFO accepts the push, so a dropped character still moves the cursor.
- FIFO: first-word-fall-through. Outputs reflect the head entry while rx_valid=1 and hold their last value when empty. A pop happens when rx_valid and rx_ready are both 1.
  - Push while full without a pop in the same cycle: the entry is dropped and overflow is set to 1. overflow clears only on reset.
  - Push and pop in the same cycle while full: both take effect, with no drop and no overflow.
  - Push and pop in the same cycle with exactly one entry: rx_valid stays 1 and the next head is the new entry.
- Reset mid-strobe: all synchronisers clear. An E already high when rstb deasserts counts only from the cycles it is seen high after reset.

Test Plan:
- Write 'H'(0x48) with rs=1 then 'i'(0x69) with rs=1, E high 4 cycles each, rx_ready=1 -> two beats: {0x48, rs=1, addr=0x00} and {0x69, rs=1, addr=0x01}; cursor_addr=0x02; rx_valid high exactly k+3 after the first E falling edge at the pin.
- Command 0xA7 (set address 0x27) then char 0x41 -> cursor_addr=0x40. Entry-mode command 0x04 then char at 0x40 -> cursor_addr=0x27. Command 0x01 -> cursor_addr=0x00 and mode returns to increment.
- rx_ready=0, issue 10 back-to-back character writes -> first 8 entries retained in order, overflow=1, cursor_addr=0x0A. Drain with rx_ready=1 -> 8 beats, then rx_valid=0.
- FIFO full plus a strobe in the same cycle as a pop -> no drop, overflow stays 0, and the new entry appears last.
- With MIN_EN_HIGH=3, a 2-cycle E pulse produces no push and no cursor change, while a 3-cycle pulse is captured. An rw=1 strobe of any width produces no push.
- Assert rstb low while E is high with 3 entries queued -> all outputs return to reset values and the FIFO is empty. After release, the E falling edge produces no push if fewer than MIN_EN_HIGH high cycles are seen.
